// File: rtl/irq_controller.sv
// Interrupt controller: rising-edge capture into a pending register, maskable,
// lowest-index-first request/acknowledge/service handshake with the core.
module irq_controller #(
    parameter int NUM_IRQ = 32
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic [31:0] i_irq_in,
    input  logic        i_mask_we,
    input  logic [31:0] i_mask_wdata,
    output logic [31:0] o_mask,
    output logic [31:0] o_pending,
    output logic        o_irq_req,
    output logic [4:0]  o_irq_id,
    input  logic        i_irq_ack,
    input  logic [4:0]  i_irq_ack_id,
    input  logic        i_isr_done,
    output logic        o_in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] IMPL_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << NUM_IRQ) - 32'd1);

    // Priority encoder: lowest set bit wins.
    function automatic logic [4:0] lowest_idx(input logic [31:0] v);
        lowest_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = i[4:0];
            end else begin
                lowest_idx = lowest_idx;
            end
        end
    endfunction

    state_t      r_state;
    logic [4:0]  r_active_id;
    logic [31:0] r_sample;
    logic [31:0] r_pending;
    logic [31:0] r_mask;
    logic        r_irq_req;
    logic [4:0]  r_irq_id;
    logic        r_in_service;

    state_t      w_state_nxt;
    logic [4:0]  w_id_nxt;
    logic        w_ack_hit;
    logic [31:0] w_enabled;
    logic [31:0] w_rise;
    logic [31:0] w_clr;

    assign w_enabled = r_pending & r_mask;
    assign w_rise    = i_irq_in & ~r_sample & IMPL_MASK;
    assign w_clr     = w_ack_hit ? (32'd1 << r_active_id) : 32'd0;

    // Next-state logic of the request/service handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_active_id;
        w_ack_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_enabled) begin
                    w_state_nxt = ST_REQUEST;
                    w_id_nxt    = lowest_idx(w_enabled);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                // A matching acknowledge beats a simultaneous mask-off.
                if (i_irq_ack && (i_irq_ack_id == r_active_id)) begin
                    w_ack_hit   = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end else if (i_mask_we && !i_mask_wdata[r_active_id]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQUEST;
                end
            end
            ST_SERVICE: begin
                if (i_isr_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Edge sampler, pending/mask registers, FSM state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            r_sample     <= 32'hFFFF_FFFF;
            r_pending    <= 32'd0;
            r_mask       <= 32'd0;
            r_state      <= ST_IDLE;
            r_active_id  <= 5'd0;
            r_irq_req    <= 1'b0;
            r_irq_id     <= 5'd0;
            r_in_service <= 1'b0;
        end else begin
            r_sample     <= i_irq_in;
            r_pending    <= (r_pending & ~w_clr) | w_rise;
            r_mask       <= i_mask_we ? (i_mask_wdata & IMPL_MASK) : r_mask;
            r_state      <= w_state_nxt;
            r_active_id  <= w_id_nxt;
            r_irq_req    <= (w_state_nxt == ST_REQUEST);
            r_irq_id     <= (w_state_nxt == ST_REQUEST) ? w_id_nxt : 5'd0;
            r_in_service <= (w_state_nxt == ST_SERVICE);
        end
    end

    assign o_mask       = r_mask;
    assign o_pending    = r_pending;
    assign o_irq_req    = r_irq_req;
    assign o_irq_id     = r_irq_id;
    assign o_in_service = r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: one table row per clock cycle, each
// row giving the inputs for that edge and the outputs expected after it.
module tb_irq_controller;

    logic        clk;
    logic        res;
    logic [31:0] irq_in;
    logic        mask_we;
    logic [31:0] mask_wdata;
    logic [31:0] mask;
    logic [31:0] pending;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack;
    logic [4:0]  irq_ack_id;
    logic        isr_done;
    logic        in_service;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        res;
        logic [31:0] irq;
        logic        we;
        logic [31:0] wdata;
        logic        ack;
        logic [4:0]  ack_id;
        logic        done;
        logic [31:0] e_pend;
        logic [31:0] e_mask;
        logic        e_req;
        logic [4:0]  e_id;
        logic        e_svc;
    } vec_t;

    vec_t vecs[$];

    irq_controller #(.NUM_IRQ(32)) dut (
        .i_clk        (clk),
        .i_res        (res),
        .i_irq_in     (irq_in),
        .i_mask_we    (mask_we),
        .i_mask_wdata (mask_wdata),
        .o_mask       (mask),
        .o_pending    (pending),
        .o_irq_req    (irq_req),
        .o_irq_id     (irq_id),
        .i_irq_ack    (irq_ack),
        .i_irq_ack_id (irq_ack_id),
        .i_isr_done   (isr_done),
        .o_in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] irq, input logic we, input logic [31:0] wd,
                       input logic ack, input logic [4:0] aid, input logic done,
                       input logic [31:0] ep, input logic [31:0] em, input logic er,
                       input logic [4:0] ei, input logic es);
        vec_t v;
        v.res = r; v.irq = irq; v.we = we; v.wdata = wd; v.ack = ack; v.ack_id = aid; v.done = done;
        v.e_pend = ep; v.e_mask = em; v.e_req = er; v.e_id = ei; v.e_svc = es;
        vecs.push_back(v);
    endtask

    task automatic step(input int n, input vec_t v);
        res = v.res; irq_in = v.irq; mask_we = v.we; mask_wdata = v.wdata;
        irq_ack = v.ack; irq_ack_id = v.ack_id; isr_done = v.done;
        @(posedge clk);
        #1;
        chk("pending",    n, pending,              v.e_pend);
        chk("mask",       n, mask,                 v.e_mask);
        chk("irq_req",    n, {31'd0, irq_req},     {31'd0, v.e_req});
        chk("irq_id",     n, {27'd0, irq_id},      {27'd0, v.e_id});
        chk("in_service", n, {31'd0, in_service}, {31'd0, v.e_svc});
    endtask

    task automatic hand(input int n, input logic r, input logic [31:0] irq, input logic we,
                        input logic [31:0] wd, input logic ack, input logic [4:0] aid, input logic done,
                        input logic [31:0] ep, input logic [31:0] em, input logic er,
                        input logic [4:0] ei, input logic es);
        vec_t v;
        v.res = r; v.irq = irq; v.we = we; v.wdata = wd; v.ack = ack; v.ack_id = aid; v.done = done;
        v.e_pend = ep; v.e_mask = em; v.e_req = er; v.e_id = ei; v.e_svc = es;
        step(n, v);
    endtask

    initial begin
        res = 1'b0; irq_in = 32'd0; mask_we = 1'b0; mask_wdata = 32'd0;
        irq_ack = 1'b0; irq_ack_id = 5'd0; isr_done = 1'b0;

        //   res irq           we wdata         ack id    done  pend          mask          req id    svc
        add(0, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h0,        32'h0,        0, 5'd0, 0);
        // single line 3
        add(1, 32'h0,        1, 32'h8,        0, 5'd0, 0,   32'h0,        32'h8,        0, 5'd0, 0);
        add(1, 32'h8,        0, 32'h0,        0, 5'd0, 0,   32'h8,        32'h8,        0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h8,        32'h8,        1, 5'd3, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd3, 0,   32'h0,        32'h8,        0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h0,        32'h8,        0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        1, 5'd3, 0,   32'h0,        32'h8,        0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h0,        32'h8,        0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h0,        32'h8,        0, 5'd0, 0);
        // lines 7 and 2 together: 2 first, then 7 back-to-back
        add(1, 32'h0,        1, 32'hFFFFFFFF, 0, 5'd0, 0,   32'h0,        32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h84,       0, 32'h0,        0, 5'd0, 0,   32'h84,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h84,       0, 32'h0,        0, 5'd0, 0,   32'h84,       32'hFFFFFFFF, 1, 5'd2, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd2, 0,   32'h80,       32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h80,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h80,       32'hFFFFFFFF, 1, 5'd7, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd7, 0,   32'h0,        32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h0,        32'hFFFFFFFF, 0, 5'd0, 0);
        // ID stability and mismatched acknowledge
        add(1, 32'h20,       0, 32'h0,        0, 5'd0, 0,   32'h20,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h20,       32'hFFFFFFFF, 1, 5'd5, 0);
        add(1, 32'h2,        0, 32'h0,        0, 5'd0, 0,   32'h22,       32'hFFFFFFFF, 1, 5'd5, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd4, 0,   32'h22,       32'hFFFFFFFF, 1, 5'd5, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd5, 0,   32'h2,        32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h20,       0, 32'h0,        0, 5'd0, 0,   32'h22,       32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h22,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h22,       32'hFFFFFFFF, 1, 5'd1, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd1, 0,   32'h20,       32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h20,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h20,       32'hFFFFFFFF, 1, 5'd5, 0);
        // mask-off withdraws, re-enable re-issues, ack beats mask-off
        add(1, 32'h0,        1, 32'h0,        0, 5'd0, 0,   32'h20,       32'h0,        0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h20,       32'h0,        0, 5'd0, 0);
        add(1, 32'h0,        1, 32'h20,       0, 5'd0, 0,   32'h20,       32'h20,       0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h20,       32'h20,       1, 5'd5, 0);
        add(1, 32'h0,        1, 32'h0,        1, 5'd5, 0,   32'h0,        32'h0,        0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h0,        32'h0,        0, 5'd0, 0);
        // set wins over clear of the same bit; done ignored in request
        add(1, 32'h10,       1, 32'hFFFFFFFF, 0, 5'd0, 0,   32'h10,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h10,       32'hFFFFFFFF, 1, 5'd4, 0);
        add(1, 32'h10,       0, 32'h0,        1, 5'd4, 0,   32'h10,       32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h10,       32'hFFFFFFFF, 0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h10,       32'hFFFFFFFF, 1, 5'd4, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h10,       32'hFFFFFFFF, 1, 5'd4, 0);
        add(1, 32'h0,        0, 32'h0,        1, 5'd4, 0,   32'h0,        32'hFFFFFFFF, 0, 5'd0, 1);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 1,   32'h0,        32'hFFFFFFFF, 0, 5'd0, 0);
        // line held high across reset must not trigger
        add(0, 32'h1,        0, 32'h0,        0, 5'd0, 0,   32'h0,        32'h0,        0, 5'd0, 0);
        add(1, 32'h1,        1, 32'h1,        0, 5'd0, 0,   32'h0,        32'h1,        0, 5'd0, 0);
        add(1, 32'h1,        0, 32'h0,        0, 5'd0, 0,   32'h0,        32'h1,        0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h0,        32'h1,        0, 5'd0, 0);
        add(1, 32'h1,        0, 32'h0,        0, 5'd0, 0,   32'h1,        32'h1,        0, 5'd0, 0);
        add(1, 32'h0,        0, 32'h0,        0, 5'd0, 0,   32'h1,        32'h1,        1, 5'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end

        // Reset in SERVICE with a same-cycle edge and ISR_DONE.
        hand(100, 1, 32'h0, 0, 32'h0, 1, 5'd0, 0,   32'h0, 32'h1, 0, 5'd0, 1);
        hand(101, 0, 32'h8, 0, 32'h0, 0, 5'd0, 1,   32'h0, 32'h0, 0, 5'd0, 0);
        hand(102, 1, 32'h8, 1, 32'h8, 0, 5'd0, 0,   32'h0, 32'h8, 0, 5'd0, 0);
        hand(103, 1, 32'h8, 0, 32'h0, 0, 5'd0, 0,   32'h0, 32'h8, 0, 5'd0, 0);
        // Reset in REQUEST beats a matching acknowledge.
        hand(104, 1, 32'h0, 0, 32'h0, 0, 5'd0, 0,   32'h0, 32'h8, 0, 5'd0, 0);
        hand(105, 1, 32'h8, 0, 32'h0, 0, 5'd0, 0,   32'h8, 32'h8, 0, 5'd0, 0);
        hand(106, 1, 32'h0, 0, 32'h0, 0, 5'd0, 0,   32'h8, 32'h8, 1, 5'd3, 0);
        hand(107, 0, 32'h0, 0, 32'h0, 1, 5'd3, 0,   32'h0, 32'h0, 0, 5'd0, 0);
        hand(108, 1, 32'h0, 0, 32'h0, 0, 5'd0, 0,   32'h0, 32'h0, 0, 5'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
